ctrl_unit_seq: RTL and testbench

- Hardwired control sequencer for the 32-bit bus CPU.
- Each clock it steps one T-state. It generates the datapath control strobes for fetch (T0–T2) and then the execute steps of the decoded instruction in IR.
- It sits beside `CPU` and drives the same strobe set that directed benches currently drive by hand.
- It samples `IR` and the condition flip-flop output, and owns run/halt status.

---
 rtl/ctrl_unit_seq.sv | 257 +++++++++++++++++++++++++
 tb/tb_ctrl_unit_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_unit_seq.sv
// Hardwired T-state control sequencer for the 32-bit bus CPU.
// Fetch runs in T0-T2, then the opcode-specific execute steps; owns run/halt status.
module ctrl_unit_seq #(
   parameter int unsigned IR_W            = 32,
   parameter bit          HALT_ON_ILLEGAL = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [IR_W-1:0] IR,
   input  logic            con_ff,
   input  logic            stop,
   output logic            run,
   output logic            PCout,
   output logic            MDRout,
   output logic            Zlowout,
   output logic            HIout,
   output logic            LOout,
   output logic            INout,
   output logic            Cout,
   output logic            BAout,
   output logic            Rout,
   output logic            PCin,
   output logic            IRin,
   output logic            MARin,
   output logic            MDRin,
   output logic            Yin,
   output logic            Zin,
   output logic            Rin,
   output logic            CONin,
   output logic            OUT_Portin,
   output logic            Gra,
   output logic            Grb,
   output logic            Grc,
   output logic            IncPC,
   output logic            Read,
   output logic            read_mem,
   output logic            write_mem,
   output logic            CON_RESET,
   output logic            ADD,
   output logic            SUB,
   output logic            AND,
   output logic            OR,
   output logic            SHR,
   output logic            SHRA,
   output logic            SHL,
   output logic            ROR,
   output logic            ROL,
   output logic            NEG,
   output logic            NOT
);

   localparam int unsigned OP_W  = 5;
   localparam int unsigned ALU_W = 11;

   localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
   localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
   localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
   localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
   localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
   localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
   localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
   localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
   localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
   localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
   localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
   localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
   localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
   localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
   localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
   localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
   localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
   localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
   localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
   localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

   // One-hot ALU select ordered {ADD,SUB,AND,OR,SHR,SHRA,SHL,ROR,ROL,NEG,NOT}
   localparam logic [ALU_W-1:0] A_ADD  = 11'b10000000000;
   localparam logic [ALU_W-1:0] A_SUB  = 11'b01000000000;
   localparam logic [ALU_W-1:0] A_AND  = 11'b00100000000;
   localparam logic [ALU_W-1:0] A_OR   = 11'b00010000000;
   localparam logic [ALU_W-1:0] A_SHR  = 11'b00001000000;
   localparam logic [ALU_W-1:0] A_SHRA = 11'b00000100000;
   localparam logic [ALU_W-1:0] A_SHL  = 11'b00000010000;
   localparam logic [ALU_W-1:0] A_ROR  = 11'b00000001000;
   localparam logic [ALU_W-1:0] A_ROL  = 11'b00000000100;
   localparam logic [ALU_W-1:0] A_NEG  = 11'b00000000010;
   localparam logic [ALU_W-1:0] A_NOT  = 11'b00000000001;

   typedef enum logic [3:0] {
      S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
   } state_e;

   typedef enum logic [3:0] {
      C_LD, C_LDI, C_ST, C_ALU_R, C_ALU_I, C_UNARY, C_BR, C_JR,
      C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT
   } cls_e;

   state_e            state_q, state_d;
   logic [OP_W-1:0]   opcode_q, opcode_d;
   logic [OP_W-1:0]   ir_op;
   logic              unused_ir;
   cls_e              cls;
   state_e            last_st;
   logic [ALU_W-1:0]  alu_oh;
   logic              alu_en;
   logic              in_exec;

   assign ir_op     = IR[IR_W-1 -: OP_W];
   assign unused_ir = ^IR[IR_W-OP_W-1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_RST;
         opcode_q <= '0;
      end else begin
         state_q  <= state_d;
         opcode_q <= opcode_d;
      end
   end

   // Instruction class, final execute state and ALU select of the latched opcode
   always_comb begin
      cls     = C_NOP;
      last_st = S_T3;
      alu_oh  = '0;
      case (opcode_q)
         OP_LD:   begin cls = C_LD;    last_st = S_T7; end
         OP_LDI:  begin cls = C_LDI;   last_st = S_T5; end
         OP_ST:   begin cls = C_ST;    last_st = S_T7; end
         OP_ADD:  begin cls = C_ALU_R; last_st = S_T5; alu_oh = A_ADD;  end
         OP_SUB:  begin cls = C_ALU_R; last_st = S_T5; alu_oh = A_SUB;  end
         OP_AND:  begin cls = C_ALU_R; last_st = S_T5; alu_oh = A_AND;  end
         OP_OR:   begin cls = C_ALU_R; last_st = S_T5; alu_oh = A_OR;   end
         OP_ROR:  begin cls = C_ALU_R; last_st = S_T5; alu_oh = A_ROR;  end
         OP_ROL:  begin cls = C_ALU_R; last_st = S_T5; alu_oh = A_ROL;  end
         OP_SHR:  begin cls = C_ALU_R; last_st = S_T5; alu_oh = A_SHR;  end
         OP_SHRA: begin cls = C_ALU_R; last_st = S_T5; alu_oh = A_SHRA; end
         OP_SHL:  begin cls = C_ALU_R; last_st = S_T5; alu_oh = A_SHL;  end
         OP_ADDI: begin cls = C_ALU_I; last_st = S_T5; alu_oh = A_ADD;  end
         OP_ANDI: begin cls = C_ALU_I; last_st = S_T5; alu_oh = A_AND;  end
         OP_ORI:  begin cls = C_ALU_I; last_st = S_T5; alu_oh = A_OR;   end
         OP_NEG:  begin cls = C_UNARY; last_st = S_T4; alu_oh = A_NEG;  end
         OP_NOT:  begin cls = C_UNARY; last_st = S_T4; alu_oh = A_NOT;  end
         OP_BR:   begin cls = C_BR;    last_st = S_T6; end
         OP_JR:   cls = C_JR;
         OP_IN:   cls = C_IN;
         OP_OUT:  cls = C_OUT;
         OP_MFHI: cls = C_MFHI;
         OP_MFLO: cls = C_MFLO;
         OP_NOP:  cls = C_NOP;
         OP_HALT: cls = C_HALT;
         default: cls = HALT_ON_ILLEGAL ? C_HALT : C_NOP;
      endcase
   end

   // Next state and strobe decode
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      alu_en   = 1'b0;
      {PCout, MDRout, Zlowout, HIout, LOout, INout, Cout, BAout, Rout} = '0;
      {PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin, OUT_Portin} = '0;
      {Gra, Grb, Grc, IncPC, Read, read_mem, write_mem, CON_RESET} = '0;
      {ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT} = '0;

      case (state_q)
         S_RST: state_d = S_T0;
         S_T0: begin
            IncPC = 1'b1; PCin = 1'b1; MARin = 1'b1; CON_RESET = 1'b1;
            state_d = S_T1;
         end
         S_T1: begin
            Read = 1'b1; read_mem = 1'b1; MDRin = 1'b1;
            state_d = S_T2;
         end
         S_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
            opcode_d = ir_op;
            state_d  = S_T3;
         end
         S_T3: begin
            state_d = S_T4;
            case (cls)
               C_LD, C_LDI, C_ST:  begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
               C_ALU_R, C_ALU_I:   begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
               C_UNARY: begin Grb = 1'b1; Rout = 1'b1; alu_en = 1'b1; Zin = 1'b1; end
               C_BR:    begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
               C_JR:    begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
               C_IN:    begin INout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_OUT:   begin Gra = 1'b1; Rout = 1'b1; OUT_Portin = 1'b1; end
               C_MFHI:  begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_MFLO:  begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               default: ;
            endcase
         end
         S_T4: begin
            state_d = S_T5;
            case (cls)
               C_LD, C_LDI, C_ST: begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
               C_ALU_R: begin Grc = 1'b1; Rout = 1'b1; alu_en = 1'b1; Zin = 1'b1; end
               C_ALU_I: begin Cout = 1'b1; alu_en = 1'b1; Zin = 1'b1; end
               C_UNARY: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_BR:    begin PCout = 1'b1; Yin = 1'b1; end
               default: ;
            endcase
         end
         S_T5: begin
            state_d = S_T6;
            case (cls)
               C_LD, C_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
               C_LDI, C_ALU_R, C_ALU_I: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_BR:    begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
               default: ;
            endcase
         end
         S_T6: begin
            state_d = S_T7;
            case (cls)
               C_LD:    begin Read = 1'b1; read_mem = 1'b1; MDRin = 1'b1; end
               C_ST:    begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
               C_BR:    begin Zlowout = 1'b1; PCin = con_ff; end
               default: ;
            endcase
         end
         S_T7: begin
            state_d = S_T0;
            case (cls)
               C_LD:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
               C_ST:    write_mem = 1'b1;
               default: ;
            endcase
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RST;
      endcase

      if (alu_en) begin
         {ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT} = alu_oh;
      end

      in_exec = (state_q == S_T3) || (state_q == S_T4) || (state_q == S_T5) ||
                (state_q == S_T6) || (state_q == S_T7);

      // stop is only honoured at an instruction boundary
      if (in_exec && (state_q == last_st)) begin
         state_d = ((cls == C_HALT) || stop) ? S_HALT : S_T0;
      end

      run = (state_q != S_RST) && (state_q != S_HALT);
   end

endmodule

// File: tb/tb_ctrl_unit_seq.sv
// Scoreboard bench for ctrl_unit_seq: driver queues hand-computed strobe vectors per cycle,
// a negedge monitor pops and compares against the live DUT outputs.
module tb_ctrl_unit_seq;
   localparam int unsigned IR_W = 32;
   localparam int unsigned V_W  = 38;
   typedef logic [V_W-1:0] vec_t;

   localparam vec_t B_NOT   = 38'd1 << 0;
   localparam vec_t B_NEG   = 38'd1 << 1;
   localparam vec_t B_ROL   = 38'd1 << 2;
   localparam vec_t B_ROR   = 38'd1 << 3;
   localparam vec_t B_SHL   = 38'd1 << 4;
   localparam vec_t B_SHRA  = 38'd1 << 5;
   localparam vec_t B_SHR   = 38'd1 << 6;
   localparam vec_t B_OR    = 38'd1 << 7;
   localparam vec_t B_AND   = 38'd1 << 8;
   localparam vec_t B_SUB   = 38'd1 << 9;
   localparam vec_t B_ADD   = 38'd1 << 10;
   localparam vec_t B_CRST  = 38'd1 << 11;
   localparam vec_t B_WRMEM = 38'd1 << 12;
   localparam vec_t B_RDMEM = 38'd1 << 13;
   localparam vec_t B_READ  = 38'd1 << 14;
   localparam vec_t B_INCPC = 38'd1 << 15;
   localparam vec_t B_GRC   = 38'd1 << 16;
   localparam vec_t B_GRB   = 38'd1 << 17;
   localparam vec_t B_GRA   = 38'd1 << 18;
   localparam vec_t B_OUTP  = 38'd1 << 19;
   localparam vec_t B_CONIN = 38'd1 << 20;
   localparam vec_t B_RIN   = 38'd1 << 21;
   localparam vec_t B_ZIN   = 38'd1 << 22;
   localparam vec_t B_YIN   = 38'd1 << 23;
   localparam vec_t B_MDRIN = 38'd1 << 24;
   localparam vec_t B_MARIN = 38'd1 << 25;
   localparam vec_t B_IRIN  = 38'd1 << 26;
   localparam vec_t B_PCIN  = 38'd1 << 27;
   localparam vec_t B_ROUT  = 38'd1 << 28;
   localparam vec_t B_BAOUT = 38'd1 << 29;
   localparam vec_t B_COUT  = 38'd1 << 30;
   localparam vec_t B_INOUT = 38'd1 << 31;
   localparam vec_t B_LOOUT = 38'd1 << 32;
   localparam vec_t B_HIOUT = 38'd1 << 33;
   localparam vec_t B_ZLOW  = 38'd1 << 34;
   localparam vec_t B_MDROUT= 38'd1 << 35;
   localparam vec_t B_PCOUT = 38'd1 << 36;
   localparam vec_t B_RUN   = 38'd1 << 37;

   localparam vec_t F0 = B_RUN | B_INCPC | B_PCIN | B_MARIN | B_CRST;
   localparam vec_t F1 = B_RUN | B_READ | B_RDMEM | B_MDRIN;
   localparam vec_t F2 = B_RUN | B_MDROUT | B_IRIN;
   localparam vec_t Z0 = '0;

   logic            clk, reset, con_ff, stop;
   logic [IR_W-1:0] IR;
   logic run, PCout, MDRout, Zlowout, HIout, LOout, INout, Cout, BAout, Rout;
   logic PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin, OUT_Portin;
   logic Gra, Grb, Grc, IncPC, Read, read_mem, write_mem, CON_RESET;
   logic ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
   vec_t act;

   vec_t  exp_q[$];
   string nm_q[$];
   int    chk_cnt  = 0;
   int    pass_cnt = 0;

   ctrl_unit_seq #(.IR_W(IR_W), .HALT_ON_ILLEGAL(1'b0)) dut (
      .clk(clk), .reset(reset), .IR(IR), .con_ff(con_ff), .stop(stop), .run(run),
      .PCout(PCout), .MDRout(MDRout), .Zlowout(Zlowout), .HIout(HIout), .LOout(LOout),
      .INout(INout), .Cout(Cout), .BAout(BAout), .Rout(Rout),
      .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin), .Zin(Zin),
      .Rin(Rin), .CONin(CONin), .OUT_Portin(OUT_Portin),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .IncPC(IncPC), .Read(Read), .read_mem(read_mem),
      .write_mem(write_mem), .CON_RESET(CON_RESET),
      .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .SHR(SHR), .SHRA(SHRA), .SHL(SHL),
      .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT)
   );

   assign act = {run, PCout, MDRout, Zlowout, HIout, LOout, INout, Cout, BAout, Rout,
                 PCin, IRin, MARin, MDRin, Yin, Zin, Rin, CONin, OUT_Portin,
                 Gra, Grb, Grc, IncPC, Read, read_mem, write_mem, CON_RESET,
                 ADD, SUB, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one expected vector per clock, compared mid-cycle
   always @(negedge clk) begin
      vec_t  e;
      string n;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         n = nm_q.pop_front();
         chk_cnt = chk_cnt + 1;
         if (act === e) pass_cnt = pass_cnt + 1;
         else $display("FAIL %s: got %h expected %h", n, act, e);
      end
   end

   task automatic step(input vec_t e, input string n);
      exp_q.push_back(e);
      nm_q.push_back(n);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input logic [IR_W-1:0] ir, input string n);
      IR = ir;
      step(F0, {n, "_T0"});
      step(F1, {n, "_T1"});
      step(F2, {n, "_T2"});
   endtask

   task automatic alu_r(input logic [IR_W-1:0] ir, input vec_t op, input string n);
      fetch(ir, n);
      step(B_RUN | B_GRB | B_ROUT | B_YIN, {n, "_T3"});
      step(B_RUN | B_GRC | B_ROUT | op | B_ZIN, {n, "_T4"});
      step(B_RUN | B_ZLOW | B_GRA | B_RIN, {n, "_T5"});
   endtask

   task automatic alu_i(input logic [IR_W-1:0] ir, input vec_t op, input string n);
      fetch(ir, n);
      step(B_RUN | B_GRB | B_ROUT | B_YIN, {n, "_T3"});
      step(B_RUN | B_COUT | op | B_ZIN, {n, "_T4"});
      step(B_RUN | B_ZLOW | B_GRA | B_RIN, {n, "_T5"});
   endtask

   task automatic unary(input logic [IR_W-1:0] ir, input vec_t op, input string n);
      fetch(ir, n);
      step(B_RUN | B_GRB | B_ROUT | op | B_ZIN, {n, "_T3"});
      step(B_RUN | B_ZLOW | B_GRA | B_RIN, {n, "_T4"});
   endtask

   task automatic single(input logic [IR_W-1:0] ir, input vec_t t3, input string n);
      fetch(ir, n);
      step(t3, {n, "_T3"});
   endtask

   task automatic br(input logic c, input string n);
      con_ff = c;
      fetch(32'h98000000, n);
      step(B_RUN | B_GRA | B_ROUT | B_CONIN, {n, "_T3"});
      step(B_RUN | B_PCOUT | B_YIN, {n, "_T4"});
      step(B_RUN | B_COUT | B_ADD | B_ZIN, {n, "_T5"});
      step(B_RUN | B_ZLOW | (c ? B_PCIN : Z0), {n, "_T6"});
      con_ff = 1'b0;
   endtask

   initial begin
      reset  = 1'b0;
      IR     = '0;
      con_ff = 1'b0;
      stop   = 1'b0;
      @(posedge clk);
      #1;
      step(Z0, "rst_hold0");
      step(Z0, "rst_hold1");
      reset = 1'b1;
      step(Z0, "rst_release");

      // ldi R5,0x65; IR disturbed after fetch must not matter
      fetch(32'h0A800065, "ldi");
      IR = 32'hD8000000;
      step(B_RUN | B_GRB | B_BAOUT | B_YIN, "ldi_T3");
      step(B_RUN | B_COUT | B_ADD | B_ZIN, "ldi_T4");
      step(B_RUN | B_ZLOW | B_GRA | B_RIN, "ldi_T5");

      fetch(32'h10800010, "st");
      step(B_RUN | B_GRB | B_BAOUT | B_YIN, "st_T3");
      step(B_RUN | B_COUT | B_ADD | B_ZIN, "st_T4");
      step(B_RUN | B_ZLOW | B_MARIN, "st_T5");
      step(B_RUN | B_GRA | B_ROUT | B_MDRIN, "st_T6");
      step(B_RUN | B_WRMEM, "st_T7");

      fetch(32'h00800010, "ld");
      step(B_RUN | B_GRB | B_BAOUT | B_YIN, "ld_T3");
      step(B_RUN | B_COUT | B_ADD | B_ZIN, "ld_T4");
      step(B_RUN | B_ZLOW | B_MARIN, "ld_T5");
      step(B_RUN | B_READ | B_RDMEM | B_MDRIN, "ld_T6");
      step(B_RUN | B_MDROUT | B_GRA | B_RIN, "ld_T7");

      alu_r(32'h18A20000, B_ADD,  "add");
      alu_r(32'h20000000, B_SUB,  "sub");
      alu_r(32'h38000000, B_ROR,  "ror");
      alu_r(32'h50000000, B_SHRA, "shra");
      alu_i(32'h60000000, B_ADD,  "addi");
      alu_i(32'h68000000, B_AND,  "andi");
      unary(32'h88000000, B_NEG,  "neg");
      unary(32'h90000000, B_NOT,  "not");
      br(1'b0, "br_c0");
      br(1'b1, "br_c1");
      single(32'hA0000000, B_RUN | B_GRA | B_ROUT | B_PCIN, "jr");
      single(32'hB0000000, B_RUN | B_INOUT | B_GRA | B_RIN, "in");
      single(32'hB8000000, B_RUN | B_GRA | B_ROUT | B_OUTP, "out");
      single(32'hC0000000, B_RUN | B_HIOUT | B_GRA | B_RIN, "mfhi");
      single(32'hC8000000, B_RUN | B_LOOUT | B_GRA | B_RIN, "mflo");
      single(32'hD0000000, B_RUN, "nop");
      single(32'hF8000000, B_RUN, "illegal");

      // stop raised early is held off until the add's last state
      fetch(32'h18A20000, "addstop");
      stop = 1'b1;
      step(B_RUN | B_GRB | B_ROUT | B_YIN, "addstop_T3");
      step(B_RUN | B_GRC | B_ROUT | B_ADD | B_ZIN, "addstop_T4");
      step(B_RUN | B_ZLOW | B_GRA | B_RIN, "addstop_T5");
      stop = 1'b0;
      for (int i = 0; i < 3; i++) step(Z0, "stop_halted");
      reset = 1'b0;
      step(Z0, "halt_rst");
      reset = 1'b1;
      step(Z0, "halt_rst_rel");

      // async reset in ld T6 kills the instruction before any write-back
      fetch(32'h00800010, "ldrst");
      step(B_RUN | B_GRB | B_BAOUT | B_YIN, "ldrst_T3");
      step(B_RUN | B_COUT | B_ADD | B_ZIN, "ldrst_T4");
      step(B_RUN | B_ZLOW | B_MARIN, "ldrst_T5");
      reset = 1'b0;
      step(Z0, "ldrst_T6_abort");
      reset = 1'b1;
      step(Z0, "ldrst_release");

      single(32'hD8000000, B_RUN, "halt");
      for (int i = 0; i < 20; i++) step(Z0, "halt_idle");

      chk_cnt = chk_cnt + 1;
      if (exp_q.size() == 0) pass_cnt = pass_cnt + 1;
      else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
